// File: rtl/ysyx_220066_ifetch_pkg.sv
// Shared encodings and helpers for the ysyx_220066 instruction-fetch line buffer.
package ysyx_220066_ifetch_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);

  function automatic logic [31:0] pick_word(input logic [63:0] line, input logic hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ysyx_220066_ifetch_if.sv
// Single-outstanding AXI-lite-style read channel between ifetch and the memory bridge.
interface ysyx_220066_ifetch_if #(
  parameter int unsigned ADDR_W = 64
) ();

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [63:0]       r_data;
  logic [1:0]        r_resp;

  modport master (
    output ar_valid,
    output ar_addr,
    output r_ready,
    input  ar_ready,
    input  r_valid,
    input  r_data,
    input  r_resp
  );

  modport slave (
    input  ar_valid,
    input  ar_addr,
    input  r_ready,
    output ar_ready,
    output r_valid,
    output r_data,
    output r_resp
  );

endinterface

// File: rtl/ysyx_220066_ifetch_lines.sv
// Direct-mapped line storage: valid/err/tag/data arrays, combinational lookup, one write
// port and flush-all. ICACHE_PREFETCH_EN adds a second probe port for the prefetch candidate.
module ysyx_220066_ifetch_lines
  import ysyx_220066_ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINES  = 4,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_rd_hit,
  output logic             o_rd_err,
  output logic [63:0]      o_rd_data,
`ifdef ICACHE_PREFETCH_EN
  input  logic [IDX_W-1:0] i_pb_idx,
  input  logic [TAG_W-1:0] i_pb_tag,
  output logic             o_pb_hit,
`endif
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_wr_err,
  input  logic [63:0]      i_wr_data
);

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_err;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [63:0]      r_data [LINES];

  // Flush takes priority so a fill landing in the flush cycle stays invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_err   <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_err[i_wr_idx]   <= i_wr_err;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_err  = r_err[i_rd_idx];
  assign o_rd_data = r_data[i_rd_idx];

`ifdef ICACHE_PREFETCH_EN
  assign o_pb_hit = r_valid[i_pb_idx] && (r_tag[i_pb_idx] == i_pb_tag);
`endif

endmodule

// File: rtl/ysyx_220066_ifetch.sv
// Instruction-fetch front end: same-cycle hit lookup, miss fill over one read channel.
// Optional next-line prefetch is enabled by defining ICACHE_PREFETCH_EN.
module ysyx_220066_ifetch
  import ysyx_220066_ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     i_pc_rd,
  input  logic                  i_fence_i,
  output logic [31:0]           o_instr,
  output logic                  o_instr_valid,
  output logic                  o_instr_error,
  ysyx_220066_ifetch_if.master  bus
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned LN_W  = ADDR_W - LINE_OFF_W;

  logic [1:0]      r_state, w_state_nxt;
  logic [LN_W-1:0] r_line,  w_line_nxt;
  logic            r_drop,  w_drop_nxt;

  logic [LN_W-1:0] w_pc_line;
  logic            w_misaligned;
  logic            w_hit;
  logic            w_err;
  logic [63:0]     w_data;
  logic            w_miss;
  logic            w_fill_done;
  logic            w_we;

  assign w_pc_line    = i_pc_rd[ADDR_W-1:LINE_OFF_W];
  assign w_misaligned = (i_pc_rd[1:0] != 2'b00);
  assign w_miss       = !w_misaligned && !w_hit;
  assign w_fill_done  = (r_state == S_WAIT) && bus.r_valid;
  assign w_we         = w_fill_done && !r_drop && !i_fence_i;

  assign bus.ar_valid = (r_state == S_REQ);
  assign bus.r_ready  = (r_state == S_WAIT);
  assign bus.ar_addr  = {r_line, {LINE_OFF_W{1'b0}}};

`ifdef ICACHE_PREFETCH_EN
  logic            r_pf_valid, w_pf_valid_nxt;
  logic [LN_W-1:0] r_pf_line,  w_pf_line_nxt;
  logic            r_is_pf,    w_is_pf_nxt;
  logic            w_pf_hit;
`endif

  ysyx_220066_ifetch_lines #(
    .ADDR_W (ADDR_W),
    .LINES  (LINES)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (i_fence_i),
    .i_rd_idx  (w_pc_line[IDX_W-1:0]),
    .i_rd_tag  (w_pc_line[LN_W-1:IDX_W]),
    .o_rd_hit  (w_hit),
    .o_rd_err  (w_err),
    .o_rd_data (w_data),
`ifdef ICACHE_PREFETCH_EN
    .i_pb_idx  (r_pf_line[IDX_W-1:0]),
    .i_pb_tag  (r_pf_line[LN_W-1:IDX_W]),
    .o_pb_hit  (w_pf_hit),
`endif
    .i_we      (w_we),
    .i_wr_idx  (r_line[IDX_W-1:0]),
    .i_wr_tag  (r_line[LN_W-1:IDX_W]),
    .i_wr_err  (bus.r_resp != RESP_OKAY),
    .i_wr_data (bus.r_data)
  );

  always_comb begin
    o_instr       = '0;
    o_instr_valid = 1'b0;
    o_instr_error = 1'b0;
    if (w_misaligned) begin
      o_instr_valid = 1'b1;
      o_instr_error = 1'b1;
    end else if (w_hit) begin
      o_instr_valid = 1'b1;
      o_instr_error = w_err;
      if (!w_err) o_instr = pick_word(w_data, i_pc_rd[2]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_drop_nxt  = r_drop;
`ifdef ICACHE_PREFETCH_EN
    w_pf_valid_nxt = r_pf_valid;
    w_pf_line_nxt  = r_pf_line;
    w_is_pf_nxt    = r_is_pf;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_state_nxt = S_REQ;
          w_line_nxt  = w_pc_line;
`ifdef ICACHE_PREFETCH_EN
          w_is_pf_nxt = 1'b0;
`endif
        end
`ifdef ICACHE_PREFETCH_EN
        else if (r_pf_valid && !w_pf_hit && !i_fence_i) begin
          w_state_nxt    = S_REQ;
          w_line_nxt     = r_pf_line;
          w_is_pf_nxt    = 1'b1;
          w_pf_valid_nxt = 1'b0;
        end
`endif
      end
      S_REQ: begin
        if (i_fence_i)    w_drop_nxt  = 1'b1;
        if (bus.ar_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.r_valid) begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
`ifdef ICACHE_PREFETCH_EN
          if (!r_is_pf) begin
            w_pf_valid_nxt = 1'b1;
            w_pf_line_nxt  = r_line + {{(LN_W-1){1'b0}}, 1'b1};
          end
`endif
        end else if (i_fence_i) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef ICACHE_PREFETCH_EN
    if (i_fence_i) w_pf_valid_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

`ifdef ICACHE_PREFETCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pf_valid <= 1'b0;
      r_pf_line  <= '0;
      r_is_pf    <= 1'b0;
    end else begin
      r_pf_valid <= w_pf_valid_nxt;
      r_pf_line  <= w_pf_line_nxt;
      r_is_pf    <= w_is_pf_nxt;
    end
  end
`endif

endmodule
